// File: rtl/trace_pkg.sv
// Shared types for the PC trace monitor: status encodings, FSM states and a pointer-width helper.
package trace_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'b000,
      ST_PASS    = 3'b001,
      ST_FAIL    = 3'b010,
      ST_TIMEOUT = 3'b011,
      ST_BREAK   = 3'b100
   } status_e;

   typedef enum logic [1:0] {
      S_RUN,
      S_DUMP,
      S_DONE
   } state_e;

   localparam int unsigned TRACE_DEPTH_DEF = 16;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned TRACE_PTR_W_DEF = ptr_w(TRACE_DEPTH_DEF);

endpackage

// File: rtl/pc_trace_monitor_if.sv
// Bundle of the CPU-side observation inputs, run status and trace dump handshake.
interface pc_trace_monitor_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            pcValid;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] instr;
   logic [2:0]      status;
   logic            done;
   logic [CW-1:0]   entryCount;
   logic            dumpValid;
   logic [XLEN-1:0] dumpData;
   logic            dumpLast;
   logic            dumpReady;

   modport master (
      output pcValid, pc, instr, dumpReady,
      input  status, done, entryCount, dumpValid, dumpData, dumpLast
   );

   modport slave (
      input  pcValid, pc, instr, dumpReady,
      output status, done, entryCount, dumpValid, dumpData, dumpLast
   );
endinterface

// File: rtl/trace_ram.sv
// DEPTH x XLEN circular trace store: synchronous write at the write pointer, registered read.
module trace_ram #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int PW    = 4,
   parameter int CW    = 5
) (
   input  logic            sysClk,
   input  logic            sysRes,
   input  logic            wr_en_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic            rd_en_i,
   input  logic [PW-1:0]   rd_addr_i,
   output logic [XLEN-1:0] rd_data_o,
   output logic [PW-1:0]   wr_ptr_o,
   output logic [CW-1:0]   entry_count_o
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] rd_data_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (wr_en_i) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      end
   end

   // Storage is not reset; only the pointers and the read register are.
   always_ff @(posedge sysClk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge sysClk or negedge sysRes) begin
      if (!sysRes) begin
         wr_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o     = rd_data_q;
   assign wr_ptr_o      = wr_ptr_q;
   assign entry_count_o = count_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor: logs PCs, flags pass/fail/timeout, dumps the trace oldest-first on fail or timeout.
// Optional debug stop on a fixed PC is built only when PC_BREAK_EN is defined.
//   state  | meaning
//   S_RUN  | logging PCs, watching sentinels and the cycle budget
//   S_DUMP | first cycle loads the read pointer, then streams beats
//   S_DONE | terminal, status held until reset
module pc_trace_monitor
   import trace_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              DEPTH          = 16,
   parameter logic [XLEN-1:0] PASS_WORD      = 32'h0000_0001,
   parameter logic [XLEN-1:0] FAIL_WORD      = 32'h0000_0000,
   parameter int unsigned     TIMEOUT_CYCLES = 50000
`ifdef PC_BREAK_EN
   ,parameter logic [XLEN-1:0] STOP_PC       = 32'h0000_00A4
`endif
) (
   input  logic               sysClk,
   input  logic               sysRes,
   pc_trace_monitor_if.slave  mon
);

   localparam int PW    = ptr_w(DEPTH);
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e           state_q, state_d;
   status_e          status_q, status_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    remain_q, remain_d;
   logic             dump_valid_q, dump_valid_d;
   logic             dump_last_q, dump_last_d;

   logic             wr_en;
   logic             rd_en;
   logic [PW-1:0]    rd_addr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    entry_count;
   logic [XLEN-1:0]  rd_data;
   logic             fail_hit, pass_hit, brk_hit, tmo_hit;

   trace_ram #(
      .XLEN (XLEN),
      .DEPTH(DEPTH),
      .PW   (PW),
      .CW   (CW)
   ) u_ram (
      .sysClk       (sysClk),
      .sysRes       (sysRes),
      .wr_en_i      (wr_en),
      .wr_data_i    (mon.pc),
      .rd_en_i      (rd_en),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .wr_ptr_o     (wr_ptr),
      .entry_count_o(entry_count)
   );

   assign wr_en    = (state_q == S_RUN) && mon.pcValid;
   assign fail_hit = mon.pcValid && (mon.instr === FAIL_WORD);
   assign pass_hit = mon.pcValid && (mon.instr === PASS_WORD);
   assign tmo_hit  = (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef PC_BREAK_EN
   assign brk_hit  = mon.pcValid && (mon.pc == STOP_PC);
`else
   assign brk_hit  = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      status_d     = status_q;
      cyc_d        = cyc_q;
      rd_ptr_d     = rd_ptr_q;
      remain_d     = remain_q;
      dump_valid_d = dump_valid_q;
      dump_last_d  = dump_last_q;
      rd_en        = 1'b0;
      rd_addr      = rd_ptr_q;
      case (state_q)
         S_RUN: begin
            cyc_d = cyc_q + CNT_W'(1);
            if (fail_hit) begin
               status_d = ST_FAIL;
               state_d  = S_DUMP;
            end else if (pass_hit) begin
               status_d = ST_PASS;
               state_d  = S_DONE;
            end else if (brk_hit) begin
               status_d = ST_BREAK;
               state_d  = S_DUMP;
            end else if (tmo_hit) begin
               status_d = ST_TIMEOUT;
               state_d  = S_DUMP;
            end
         end
         S_DUMP: begin
            // The entry edge also logged the final PC, so pointer and count are read one cycle later.
            if (!dump_valid_q) begin
               if (entry_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  rd_en        = 1'b1;
                  rd_addr      = (entry_count == CW'(DEPTH)) ? wr_ptr : '0;
                  rd_ptr_d     = rd_addr + PW'(1);
                  remain_d     = entry_count;
                  dump_valid_d = 1'b1;
                  dump_last_d  = (entry_count == CW'(1));
               end
            end else if (mon.dumpReady) begin
               if (remain_q == CW'(1)) begin
                  dump_valid_d = 1'b0;
                  dump_last_d  = 1'b0;
                  state_d      = S_DONE;
               end else begin
                  rd_en       = 1'b1;
                  rd_ptr_d    = rd_ptr_q + PW'(1);
                  remain_d    = remain_q - CW'(1);
                  dump_last_d = (remain_q == CW'(2));
               end
            end
         end
         S_DONE: begin
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge sysClk or negedge sysRes) begin
      if (!sysRes) begin
         state_q      <= S_RUN;
         status_q     <= ST_RUN;
         cyc_q        <= '0;
         rd_ptr_q     <= '0;
         remain_q     <= '0;
         dump_valid_q <= 1'b0;
         dump_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         status_q     <= status_d;
         cyc_q        <= cyc_d;
         rd_ptr_q     <= rd_ptr_d;
         remain_q     <= remain_d;
         dump_valid_q <= dump_valid_d;
         dump_last_q  <= dump_last_d;
      end
   end

   assign mon.status     = status_q;
   assign mon.done       = (state_q == S_DONE);
   assign mon.entryCount = entry_count;
   assign mon.dumpValid  = dump_valid_q;
   assign mon.dumpData   = rd_data;
   assign mon.dumpLast   = dump_last_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scoreboard bench for pc_trace_monitor; expected dump beats are queued from the bench's own PC log.
module tb_pc_trace_monitor;
   import trace_pkg::*;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] PASSW = 32'h0000_0001;
   localparam logic [31:0] FAILW = 32'h0000_0000;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] log_q[$];
   logic [31:0] exp_q[$];

   pc_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH)) mon ();

   pc_trace_monitor #(
      .XLEN          (XLEN),
      .DEPTH         (DEPTH),
      .PASS_WORD     (PASSW),
      .FAIL_WORD     (FAILW),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .sysClk(clk),
      .sysRes(rst_n),
      .mon   (mon)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      mon.pcValid   = 1'b0;
      mon.pc        = '0;
      mon.instr     = NOP;
      mon.dumpReady = 1'b0;
      rst_n         = 1'b0;
      log_q.delete();
      exp_q.delete();
      step();
      step();
      check_val("rst_status", 64'(mon.status), 64'(ST_RUN));
      check_val("rst_done", 64'(mon.done), 0);
      check_val("rst_count", 64'(mon.entryCount), 0);
      check_val("rst_dvalid", 64'(mon.dumpValid), 0);
      check_val("rst_ddata", 64'(mon.dumpData), 0);
      check_val("rst_dlast", 64'(mon.dumpLast), 0);
      rst_n = 1'b1;
   endtask

   // Drives n consecutive valid PCs base+4*i; the sentinel word goes on index sent_idx.
   task automatic drive_pcs(input logic [31:0] base, input int start, input int n,
                            input int sent_idx, input logic [31:0] word);
      for (int i = start; i < start + n; i++) begin
         mon.pcValid = 1'b1;
         mon.pc      = base + 32'(i * 4);
         mon.instr   = (i == sent_idx) ? word : NOP;
         log_q.push_back(mon.pc);
         step();
      end
   endtask

   function automatic void expect_dump();
      int n;
      int first;
      n     = log_q.size();
      first = (n > DEPTH) ? n - DEPTH : 0;
      exp_q.delete();
      for (int i = first; i < n; i++) exp_q.push_back(log_q[i]);
   endfunction

   task automatic run_dump(input bit rnd, input int beat_limit, input int budget, input bit final_chk);
      int          beats;
      int          total;
      int          cyc;
      bit          stalled;
      logic [31:0] held;
      logic [31:0] exp;
      beats   = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      total   = exp_q.size();
      while (mon.done !== 1'b1 && beats < beat_limit && cyc < budget) begin
         if (stalled) begin
            check_val("stall_valid", 64'(mon.dumpValid), 1);
            check_val("stall_hold", 64'(mon.dumpData), 64'(held));
         end
         mon.dumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (mon.dumpValid === 1'b1) begin
            if (mon.dumpReady) begin
               if (exp_q.size() == 0) begin
                  check_val("extra_beat", 64'(mon.dumpValid), 0);
               end else begin
                  exp = exp_q.pop_front();
                  check_val("dump_data", 64'(mon.dumpData), 64'(exp));
                  check_val("dump_last", 64'(mon.dumpLast), 64'(exp_q.size() == 0));
               end
               beats++;
            end else begin
               stalled = 1'b1;
               held    = mon.dumpData;
            end
         end
         step();
         cyc++;
      end
      if (mon.done !== 1'b1 && beats < beat_limit) check_val("dump_budget", 64'(mon.done), 1);
      if (final_chk) begin
         check_val("beat_count", 64'(beats), 64'(total));
         check_val("beats_left", 64'(exp_q.size()), 0);
         check_val("dvalid_done", 64'(mon.dumpValid), 0);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      mon.pcValid   = 1'b0;
      mon.pc        = '0;
      mon.instr     = NOP;
      mon.dumpReady = 1'b0;

      // PASS on the 5th valid PC: done next cycle, no dump, no further logging
      do_reset();
      drive_pcs(32'h0, 0, 5, 4, PASSW);
      mon.pcValid = 1'b0;
      check_val("pass_status", 64'(mon.status), 64'(ST_PASS));
      check_val("pass_done", 64'(mon.done), 1);
      check_val("pass_count", 64'(mon.entryCount), 5);
      drive_pcs(32'h100, 0, 3, -1, NOP);
      mon.pcValid = 1'b0;
      check_val("pass_nolog", 64'(mon.entryCount), 5);
      check_val("pass_nodump", 64'(mon.dumpValid), 0);
      check_val("pass_hold", 64'(mon.status), 64'(ST_PASS));

      // FAIL after wrap: 20 PCs, dump shows the newest 16
      do_reset();
      drive_pcs(32'h0, 0, 20, 19, FAILW);
      mon.pcValid = 1'b0;
      check_val("wrap_status", 64'(mon.status), 64'(ST_FAIL));
      check_val("wrap_count", 64'(mon.entryCount), 16);
      expect_dump();
      check_val("wrap_first", 64'(exp_q[0]), 64'h10);
      run_dump(1'b0, 1000, 200, 1'b1);
      check_val("wrap_done", 64'(mon.done), 1);
      check_val("wrap_status_hold", 64'(mon.status), 64'(ST_FAIL));

      // FAIL on the 3rd PC: partial buffer dumped from slot 0
      do_reset();
      drive_pcs(32'h0, 0, 3, 2, FAILW);
      mon.pcValid = 1'b0;
      check_val("short_count", 64'(mon.entryCount), 3);
      expect_dump();
      run_dump(1'b0, 1000, 50, 1'b1);
      check_val("short_status", 64'(mon.status), 64'(ST_FAIL));

      // Timeout with PCs every cycle: status flips exactly at edge 100
      do_reset();
      drive_pcs(32'h2000, 0, 99, -1, NOP);
      check_val("tmo_pre", 64'(mon.status), 64'(ST_RUN));
      drive_pcs(32'h2000, 99, 1, -1, NOP);
      mon.pcValid = 1'b0;
      check_val("tmo_status", 64'(mon.status), 64'(ST_TIMEOUT));
      expect_dump();
      run_dump(1'b0, 1000, 200, 1'b1);
      check_val("tmo_done", 64'(mon.done), 1);

      // Timeout with nothing logged: straight to DONE, no beats
      do_reset();
      for (int i = 0; i < 99; i++) step();
      check_val("tmo0_pre", 64'(mon.status), 64'(ST_RUN));
      step();
      check_val("tmo0_status", 64'(mon.status), 64'(ST_TIMEOUT));
      check_val("tmo0_count", 64'(mon.entryCount), 0);
      exp_q.delete();
      run_dump(1'b0, 1000, 20, 1'b1);

      // Random backpressure over a full wrapped dump
      do_reset();
      drive_pcs(32'h1000, 0, 20, 19, FAILW);
      mon.pcValid = 1'b0;
      expect_dump();
      run_dump(1'b1, 1000, 1000, 1'b1);
      check_val("bp_status", 64'(mon.status), 64'(ST_FAIL));

      // Reset asserted mid-dump clears outputs without waiting for a clock
      do_reset();
      drive_pcs(32'h3000, 0, 20, 19, FAILW);
      mon.pcValid = 1'b0;
      expect_dump();
      run_dump(1'b1, 6, 1000, 1'b0);
      check_val("mid_dvalid_pre", 64'(mon.dumpValid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_status", 64'(mon.status), 64'(ST_RUN));
      check_val("mid_done", 64'(mon.done), 0);
      check_val("mid_count", 64'(mon.entryCount), 0);
      check_val("mid_dvalid", 64'(mon.dumpValid), 0);
      check_val("mid_ddata", 64'(mon.dumpData), 0);
      check_val("mid_dlast", 64'(mon.dumpLast), 0);

      // PC reaching the break address
      do_reset();
      drive_pcs(32'h0, 0, 42, -1, NOP);
      mon.pcValid = 1'b0;
`ifdef PC_BREAK_EN
      check_val("brk_status", 64'(mon.status), 64'(ST_BREAK));
      expect_dump();
      check_val("brk_newest", 64'(exp_q[exp_q.size() - 1]), 64'h0A4);
      run_dump(1'b0, 1000, 200, 1'b1);
      check_val("brk_done", 64'(mon.done), 1);
`else
      check_val("nobrk_status", 64'(mon.status), 64'(ST_RUN));
      check_val("nobrk_done", 64'(mon.done), 0);
      step();
      step();
      check_val("nobrk_hold", 64'(mon.status), 64'(ST_RUN));
      check_val("nobrk_dvalid", 64'(mon.dumpValid), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
